// File: rtl/dma_cpu_cache_sp_responder.sv
// Scratchpad responder for the DMA cpu_cache request/response port.
// Line-organised SRAM with per-byte write masks; reads return whole lines
// in accept order through a credit-controlled response FIFO.

package dma_cpu_cache_pkg;
  localparam logic [1:0] REQ_READ  = 2'd0;
  localparam logic [1:0] REQ_WRITE = 2'd1;

  typedef struct packed {
    logic [31:0]  req_paddr;
    logic [31:0]  req_mask;
    logic [255:0] req_data;
    logic [7:0]   req_tid;
    logic [1:0]   req_type;
  } cpu_cache_if_req_t;

  typedef struct packed {
    logic [7:0]   resp_tid;
    logic [31:0]  resp_mask;
    logic [255:0] resp_data;
  } cpu_cache_if_resp_t;
endpackage

module dma_cpu_cache_sp_responder
  import dma_cpu_cache_pkg::*;
#(
  parameter int          SP_LINES       = 256,
  parameter int          RSP_FIFO_DEPTH = 4,
  parameter logic [31:0] SP_BASE_ADDR   = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               cpu_cache_req_if_req_valid,
  input  cpu_cache_if_req_t  cpu_cache_req_if_req,
  output logic               cpu_cache_req_if_req_ready,
  output logic               cpu_cache_resp_if_resp_valid,
  output cpu_cache_if_resp_t cpu_cache_resp_if_resp,
  input  logic               cpu_cache_resp_if_resp_ready,
  output logic               sp_idle,
  output logic [15:0]        sp_addr_err_cnt
);

  localparam int          IDX_W    = (SP_LINES > 1) ? $clog2(SP_LINES) : 1;
  localparam int          PTR_W    = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;
  localparam int          CNT_W    = $clog2(RSP_FIFO_DEPTH) + 1;
  localparam logic [31:0] SP_BYTES = 32'(SP_LINES * 32);

  // Storage
  logic [255:0]     mem_r       [SP_LINES];
  logic [7:0]       fifo_tid_r  [RSP_FIFO_DEPTH];
  logic [31:0]      fifo_mask_r [RSP_FIFO_DEPTH];
  logic [255:0]     fifo_data_r [RSP_FIFO_DEPTH];

  // Pipeline and control state
  logic             s1_valid_r;
  logic [7:0]       s1_tid_r;
  logic [31:0]      s1_mask_r;
  logic [255:0]     s1_data_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             ready_r;
  logic             idle_r;
  logic [15:0]      err_cnt_r;

  // Decode / next-state
  logic [31:0]      offset_s;
  logic             in_range_s;
  logic [IDX_W-1:0] idx_s;
  logic             accept_s;
  logic             is_write_s;
  logic             wr_en_s;
  logic             rd_accept_s;
  logic             push_s;
  logic             pop_s;
  logic [CNT_W-1:0] count_next_s;
  logic [CNT_W:0]   credit_sum_s;
  logic             ready_next_s;
  logic             idle_next_s;
  logic [15:0]      err_next_s;
  logic [255:0]     rd_line_s;

  // Request decode, range check, credit and counter next-state
  always_comb begin
    // Offset wraps for addresses below the base, so one unsigned compare covers both bounds.
    offset_s     = cpu_cache_req_if_req.req_paddr - SP_BASE_ADDR;
    in_range_s   = (offset_s < SP_BYTES);
    idx_s        = offset_s[5 +: IDX_W];
    accept_s     = cpu_cache_req_if_req_valid & ready_r;
    is_write_s   = (cpu_cache_req_if_req.req_type == REQ_WRITE);
    wr_en_s      = accept_s & is_write_s & in_range_s;
    rd_accept_s  = accept_s & ~is_write_s;
    push_s       = s1_valid_r;
    pop_s        = (count_r != {CNT_W{1'b0}}) & cpu_cache_resp_if_resp_ready;
    count_next_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    // ready is registered from next-state so resp_ready never reaches it combinationally.
    credit_sum_s = {1'b0, count_next_s} + (CNT_W + 1)'(rd_accept_s);
    ready_next_s = (credit_sum_s < (CNT_W + 1)'(RSP_FIFO_DEPTH));
    idle_next_s  = ~rd_accept_s & (count_next_s == {CNT_W{1'b0}});
    if (accept_s & ~in_range_s & (err_cnt_r != 16'hFFFF)) begin
      err_next_s = err_cnt_r + 16'd1;
    end else begin
      err_next_s = err_cnt_r;
    end
    if (in_range_s) begin
      rd_line_s = mem_r[idx_s];
    end else begin
      rd_line_s = {256{1'b0}};
    end
  end

  // Byte-masked line writes; SRAM contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int i = 0; i < 32; i++) begin
        if (cpu_cache_req_if_req.req_mask[i]) begin
          mem_r[idx_s][i*8 +: 8] <= cpu_cache_req_if_req.req_data[i*8 +: 8];
        end
      end
    end
  end

  // S1 payload capture and FIFO payload storage (qualified by control state)
  always_ff @(posedge clk) begin
    if (rd_accept_s) begin
      s1_tid_r  <= cpu_cache_req_if_req.req_tid;
      s1_mask_r <= cpu_cache_req_if_req.req_mask;
      s1_data_r <= rd_line_s;
    end
    if (push_s) begin
      fifo_tid_r[wr_ptr_r]  <= s1_tid_r;
      fifo_mask_r[wr_ptr_r] <= s1_mask_r;
      fifo_data_r[wr_ptr_r] <= s1_data_r;
    end
  end

  // Control state: S1 valid, FIFO pointers/count, ready, idle, error counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_r <= 1'b0;
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      ready_r    <= 1'b0;
      idle_r     <= 1'b1;
      err_cnt_r  <= 16'h0000;
    end else begin
      s1_valid_r <= rd_accept_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r   <= count_next_s;
      ready_r   <= ready_next_s;
      idle_r    <= idle_next_s;
      err_cnt_r <= err_next_s;
    end
  end

  assign cpu_cache_req_if_req_ready       = ready_r;
  assign cpu_cache_resp_if_resp_valid     = (count_r != {CNT_W{1'b0}});
  assign cpu_cache_resp_if_resp.resp_tid  = fifo_tid_r[rd_ptr_r];
  assign cpu_cache_resp_if_resp.resp_mask = fifo_mask_r[rd_ptr_r];
  assign cpu_cache_resp_if_resp.resp_data = fifo_data_r[rd_ptr_r];
  assign sp_idle                          = idle_r;
  assign sp_addr_err_cnt                  = err_cnt_r;

endmodule

// File: tb/tb_dma_cpu_cache_sp_responder.sv
// Directed bench for dma_cpu_cache_sp_responder: table of single requests
// plus hand sequences for latency, backpressure, read-after-write and reset.
module tb_dma_cpu_cache_sp_responder;
  import dma_cpu_cache_pkg::*;

  localparam logic [31:0] B = 32'h0001_0000;

  logic               clk;
  logic               rstn;
  logic               req_valid;
  cpu_cache_if_req_t  req;
  logic               req_ready;
  logic               resp_valid;
  cpu_cache_if_resp_t resp;
  logic               resp_ready;
  logic               sp_idle;
  logic [15:0]        err_cnt;

  int errors = 0;
  int checks = 0;

  dma_cpu_cache_sp_responder #(
    .SP_LINES(256), .RSP_FIFO_DEPTH(4), .SP_BASE_ADDR(B)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .cpu_cache_req_if_req_valid(req_valid),
    .cpu_cache_req_if_req(req),
    .cpu_cache_req_if_req_ready(req_ready),
    .cpu_cache_resp_if_resp_valid(resp_valid),
    .cpu_cache_resp_if_resp(resp),
    .cpu_cache_resp_if_resp_ready(resp_ready),
    .sp_idle(sp_idle),
    .sp_addr_err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  paddr;
    logic [31:0]  mask;
    logic [255:0] data;
    logic [7:0]   tid;
    logic [1:0]   typ;
    logic         exp_resp;
    logic [7:0]   exp_tid;
    logic [31:0]  exp_mask;
    logic [255:0] exp_data;
    logic [15:0]  exp_err;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request and hold it until accepted (bounded).
  task automatic send(input logic [31:0] paddr, input logic [31:0] mask, input logic [255:0] data,
                      input logic [7:0] tid, input logic [1:0] typ);
    int n;
    req.req_paddr = paddr;
    req.req_mask  = mask;
    req.req_data  = data;
    req.req_tid   = tid;
    req.req_type  = typ;
    req_valid     = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    if (!req_ready) check("send_ready_timeout", 256'(req_ready), 256'(1'b1));
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input string name);
    int n;
    n = 0;
    while (!resp_valid && n < 10) begin
      tick();
      n++;
    end
    check({name, "_valid"}, 256'(resp_valid), 256'(1'b1));
  endtask

  logic [255:0] pat_v;
  logic [255:0] l7_v;
  logic [255:0] raw_v;
  logic         was_ready;
  int           n_acc;
  int           k;
  int           budget;

  initial begin
    for (int i = 0; i < 32; i++) pat_v[i*8 +: 8] = 8'(i);
    l7_v  = {{24{8'h55}}, {4{8'hAA}}, {4{8'h55}}};
    raw_v = {8{32'hDEAD_BEEF}};

    vecs[0] = '{B + 32'h60,   32'hFFFF_FFFF, pat_v,          8'h01, REQ_WRITE, 1'b0, 8'h00, 32'h0,         256'h0, 16'd0};
    vecs[1] = '{B + 32'h60,   32'h0000_FF00, {32{8'hEE}},    8'h05, REQ_READ,  1'b1, 8'h05, 32'h0000_FF00, pat_v,  16'd0};
    vecs[2] = '{B + 32'hE0,   32'hFFFF_FFFF, {32{8'h55}},    8'h02, REQ_WRITE, 1'b0, 8'h00, 32'h0,         256'h0, 16'd0};
    vecs[3] = '{B + 32'hFB,   32'h0000_00F0, {32{8'hAA}},    8'h03, REQ_WRITE, 1'b0, 8'h00, 32'h0,         256'h0, 16'd0};
    vecs[4] = '{B + 32'hE4,   32'hFFFF_FFFF, 256'h0,         8'h09, REQ_READ,  1'b1, 8'h09, 32'hFFFF_FFFF, l7_v,   16'd0};
    vecs[5] = '{B + 32'h2000, 32'h0000_0003, 256'h0,         8'h11, REQ_READ,  1'b1, 8'h11, 32'h0000_0003, 256'h0, 16'd1};
    vecs[6] = '{B + 32'h2060, 32'hFFFF_FFFF, {32{8'hFF}},    8'h12, REQ_WRITE, 1'b0, 8'h00, 32'h0,         256'h0, 16'd2};
    vecs[7] = '{B + 32'h60,   32'h0000_0001, 256'h0,         8'h06, 2'd3,      1'b1, 8'h06, 32'h0000_0001, pat_v,  16'd2};
    vecs[8] = '{B - 32'h20,   32'h8000_0000, 256'h0,         8'h22, REQ_READ,  1'b1, 8'h22, 32'h8000_0000, 256'h0, 16'd3};

    rstn       = 1'b0;
    req_valid  = 1'b0;
    req        = '0;
    resp_ready = 1'b1;

    // Reset state
    #12;
    check("rst_resp_valid", 256'(resp_valid), 256'(1'b0));
    check("rst_idle",       256'(sp_idle),    256'(1'b1));
    check("rst_err_cnt",    256'(err_cnt),    256'(16'd0));
    check("rst_req_ready",  256'(req_ready),  256'(1'b0));
    #10 rstn = 1'b1;
    tick();
    check("ready_after_rst", 256'(req_ready), 256'(1'b1));

    // Table of single requests
    for (int v = 0; v < 9; v++) begin
      send(vecs[v].paddr, vecs[v].mask, vecs[v].data, vecs[v].tid, vecs[v].typ);
      if (vecs[v].exp_resp) begin
        wait_resp($sformatf("vec%0d", v));
        check($sformatf("vec%0d_tid", v),  256'(resp.resp_tid),  256'(vecs[v].exp_tid));
        check($sformatf("vec%0d_mask", v), 256'(resp.resp_mask), 256'(vecs[v].exp_mask));
        check($sformatf("vec%0d_data", v), resp.resp_data,       vecs[v].exp_data);
        tick();
      end else begin
        tick();
        tick();
        check($sformatf("vec%0d_no_resp", v), 256'(resp_valid), 256'(1'b0));
      end
      check($sformatf("vec%0d_err", v), 256'(err_cnt), 256'(vecs[v].exp_err));
    end

    // Read latency: nothing after the accept edge, response after the next one
    send(B + 32'h60, 32'h0000_FF00, 256'h0, 8'h05, REQ_READ);
    check("lat_edge1_valid", 256'(resp_valid), 256'(1'b0));
    check("lat_edge1_idle",  256'(sp_idle),    256'(1'b0));
    tick();
    check("lat_edge2_valid", 256'(resp_valid),     256'(1'b1));
    check("lat_tid",         256'(resp.resp_tid),  256'(8'h05));
    check("lat_mask",        256'(resp.resp_mask), 256'(32'h0000_FF00));
    check("lat_data",        resp.resp_data,       pat_v);
    tick();
    check("lat_drained_idle", 256'(sp_idle), 256'(1'b1));

    // Backpressure: 6 back-to-back reads with resp_ready low
    resp_ready = 1'b0;
    n_acc = 0;
    req.req_paddr = B + 32'h60;
    req.req_type  = REQ_READ;
    req.req_data  = 256'h0;
    for (int c = 0; c < 6; c++) begin
      req.req_tid  = 8'(n_acc);
      req.req_mask = 32'(n_acc);
      req_valid    = 1'b1;
      was_ready    = req_ready;
      tick();
      if (was_ready) n_acc++;
    end
    check("bp_accepts",  256'(n_acc),          256'(4));
    check("bp_ready",    256'(req_ready),      256'(1'b0));
    check("bp_head_tid", 256'(resp.resp_tid),  256'(8'h00));
    resp_ready = 1'b1;
    check("bp_ready_no_comb", 256'(req_ready), 256'(1'b0));
    k = 0;
    budget = 0;
    while (k < 6 && budget < 40) begin
      if (resp_valid) begin
        check($sformatf("bp_tid%0d", k),  256'(resp.resp_tid),  256'(8'(k)));
        check($sformatf("bp_mask%0d", k), 256'(resp.resp_mask), 256'(32'(k)));
        check($sformatf("bp_data%0d", k), resp.resp_data,       pat_v);
        k++;
      end
      req_valid    = (n_acc < 6);
      req.req_tid  = 8'(n_acc);
      req.req_mask = 32'(n_acc);
      was_ready    = req_ready;
      tick();
      if (budget == 0) check("bp_ready_after_pop", 256'(req_ready), 256'(1'b1));
      if (was_ready && req_valid) n_acc++;
      budget++;
    end
    req_valid = 1'b0;
    check("bp_resp_count", 256'(k), 256'(6));
    tick();
    tick();
    check("bp_no_dup",   256'(resp_valid), 256'(1'b0));
    check("bp_idle_end", 256'(sp_idle),    256'(1'b1));

    // Read-after-write on consecutive edges
    send(B + 32'h140, 32'hFFFF_FFFF, raw_v, 8'h30, REQ_WRITE);
    send(B + 32'h140, 32'hFFFF_FFFF, 256'h0, 8'h33, REQ_READ);
    wait_resp("raw");
    check("raw_tid",  256'(resp.resp_tid), 256'(8'h33));
    check("raw_data", resp.resp_data,      raw_v);
    tick();

    // Reset with three responses pending
    resp_ready = 1'b0;
    send(B + 32'hE0, 32'h1, 256'h0, 8'h40, REQ_READ);
    send(B + 32'hE0, 32'h1, 256'h0, 8'h41, REQ_READ);
    send(B + 32'hE0, 32'h1, 256'h0, 8'h42, REQ_READ);
    tick();
    tick();
    check("pre_rst_valid", 256'(resp_valid), 256'(1'b1));
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_valid", 256'(resp_valid), 256'(1'b0));
    check("mid_rst_idle",  256'(sp_idle),    256'(1'b1));
    check("mid_rst_err",   256'(err_cnt),    256'(16'd0));
    resp_ready = 1'b1;
    tick();
    #3 rstn = 1'b1;
    tick();
    check("post_rst_ready", 256'(req_ready),  256'(1'b1));
    check("post_rst_valid", 256'(resp_valid), 256'(1'b0));
    send(B + 32'h140, 32'hFFFF_FFFF, 256'h0, 8'h77, REQ_READ);
    wait_resp("post_rst");
    check("post_rst_tid",  256'(resp.resp_tid), 256'(8'h77));
    check("post_rst_data", resp.resp_data,      raw_v);
    tick();
    send(B + 32'hE0, 32'hFFFF_FFFF, 256'h0, 8'h78, REQ_READ);
    wait_resp("post_rst_l7");
    check("post_rst_l7_data", resp.resp_data, l7_v);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
